// File: rtl/ascon_axis_padder.sv
// Ascon input padder: applies 10* byte padding to AD/PT/MSG/Z segments and injects a pad lane after a full final beat.
// Latency 1 cycle (registered lane); s_axis_tready = PASS && slot free, so the stage stalls on blk_ready and during PAD.
// Optional ASCON_PADDER_STATS_EN adds stat_lanes/stat_segs. TUSER: 0 RES,1 KEY,2 NONCE,3 AD,4 PT,5 CT,6 TAG,7 MSG,8 Z,9 DIGEST.
module ascon_axis_padder #(
    parameter int LANE_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic [3:0]  s_axis_tuser,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] blk_data,
    output logic [3:0]  blk_type,
    output logic [7:0]  blk_keep,
    output logic        blk_last,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        err_keep
`ifdef ASCON_PADDER_STATS_EN
    ,
    output logic [31:0] stat_lanes,
    output logic [15:0] stat_segs
`endif
);
    localparam int WORD_WIDTH = 64;

    if (LANE_BYTES != WORD_WIDTH / 8) begin : g_bad_lane_bytes
        $error("LANE_BYTES must equal WORD_WIDTH/8");
    end

    typedef enum logic [3:0] {
        TUSER_RESERVED = 4'd0,
        TUSER_KEY      = 4'd1,
        TUSER_NONCE    = 4'd2,
        TUSER_AD       = 4'd3,
        TUSER_PT       = 4'd4,
        TUSER_CT       = 4'd5,
        TUSER_TAG      = 4'd6,
        TUSER_MSG      = 4'd7,
        TUSER_Z        = 4'd8,
        TUSER_DIGEST   = 4'd9
    } axi_tuser_t;

    typedef enum logic {ST_PASS, ST_PAD} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_valid, r_last, r_err;
    logic [63:0] r_data;
    logic [3:0]  r_type;
    logic [7:0]  r_keep;

    logic        w_slot_free, w_accept, w_is_pad, w_is_raw;
    logic [3:0]  w_n;
    logic        w_gap, w_seen_zero;
    logic [63:0] w_masked, w_padded;
    logic        w_load, w_err_set, w_ld_last;
    logic [63:0] w_ld_data;
    logic [3:0]  w_ld_type;
    logic [7:0]  w_ld_keep;

    assign w_slot_free   = !r_valid || blk_ready;
    assign s_axis_tready = (r_state == ST_PASS) && w_slot_free;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    assign w_is_pad = (s_axis_tuser == TUSER_AD) || (s_axis_tuser == TUSER_PT) ||
                      (s_axis_tuser == TUSER_MSG) || (s_axis_tuser == TUSER_Z);
    assign w_is_raw = (s_axis_tuser == TUSER_KEY) || (s_axis_tuser == TUSER_NONCE) ||
                      (s_axis_tuser == TUSER_CT) || (s_axis_tuser == TUSER_TAG);

    // n = trailing ones of tkeep; any 1 above the first 0 is a gap (non-contiguous mask)
    always_comb begin
        w_n         = 4'd0;
        w_gap       = 1'b0;
        w_seen_zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!s_axis_tkeep[i]) begin
                w_seen_zero = 1'b1;
            end else if (w_seen_zero) begin
                w_gap = 1'b1;
            end else begin
                w_n = w_n + 4'd1;
            end
        end
    end

    always_comb begin
        w_masked = '0;
        w_padded = '0;
        for (int i = 0; i < 8; i++) begin
            w_masked[8*i +: 8] = (4'(i) < w_n) ? s_axis_tdata[8*i +: 8] : 8'h00;
            w_padded[8*i +: 8] = (4'(i) == w_n) ? 8'h01 : w_masked[8*i +: 8];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_err_set   = 1'b0;
        w_ld_data   = w_masked;
        w_ld_type   = s_axis_tuser;
        w_ld_keep   = s_axis_tkeep;
        w_ld_last   = 1'b0;
        if (r_state == ST_PAD) begin
            w_ld_data = 64'h0000_0000_0000_0001;
            w_ld_type = r_type;
            w_ld_keep = 8'h00;
            w_ld_last = 1'b1;
            if (w_slot_free) begin
                w_load      = 1'b1;
                w_state_nxt = ST_PASS;
            end
        end else if (w_accept) begin
            if (w_is_pad) begin
                w_load    = 1'b1;
                w_err_set = w_gap || (!s_axis_tlast && (s_axis_tkeep != 8'hFF));
                if (s_axis_tlast) begin
                    // A full final beat has no room for the pad byte: emit it as a separate lane
                    if (w_n == 4'd8) begin
                        w_state_nxt = ST_PAD;
                    end else begin
                        w_ld_data = w_padded;
                        w_ld_last = 1'b1;
                    end
                end
            end else if (w_is_raw) begin
                w_load    = 1'b1;
                w_err_set = w_gap;
                w_ld_last = s_axis_tlast;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_PASS;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_type  <= TUSER_RESERVED;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_ld_data;
                r_type  <= w_ld_type;
                r_keep  <= w_ld_keep;
                r_last  <= w_ld_last;
            end else if (blk_ready) begin
                r_valid <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign blk_valid = r_valid;
    assign blk_data  = r_data;
    assign blk_type  = r_type;
    assign blk_keep  = r_keep;
    assign blk_last  = r_last;
    assign err_keep  = r_err;

`ifdef ASCON_PADDER_STATS_EN
    logic [31:0] r_stat_lanes;
    logic [15:0] r_stat_segs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_lanes <= '0;
            r_stat_segs  <= '0;
        end else if (r_valid && blk_ready) begin
            r_stat_lanes <= r_stat_lanes + 32'd1;
            if (r_last) begin
                r_stat_segs <= r_stat_segs + 16'd1;
            end
        end
    end

    assign stat_lanes = r_stat_lanes;
    assign stat_segs  = r_stat_segs;
`endif
endmodule
